// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one synchronous single-port sprite/board ROM between the pixel
// display fetch (requester 0, absolute priority) and two auxiliary
// requesters (overlay / animation) that share leftover slots round-robin.
// Each issued read carries a tag down a pipeline matched to the ROM latency
// so the returning data strobes the requester that issued it.
// Auxiliary requesters that wait too long raise a sticky starve flag.
//
// Ports
//   vga_clk     sole clock, rising edge
//   reset       synchronous, active-high
//   disp_req    display fetch request (never back-pressured)
//   disp_addr   display fetch address
//   disp_q      display return data (rom_q passthrough)
//   disp_valid  display return strobe
//   aux_req     auxiliary requests, bit i = requester i+1
//   aux_addr0   address for aux requester 1
//   aux_addr1   address for aux requester 2
//   aux_gnt     combinational grant, one-hot or zero
//   aux_q       auxiliary return data (rom_q passthrough)
//   aux_valid   auxiliary return strobe, one-hot or zero
//   rom_addr    registered ROM address
//   rom_q       ROM read data, valid ROM_LAT cycles after rom_addr
//   starve      sticky starvation flags
//   starve_clr  clears both starve flags and both wait counters
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 4,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 1023
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_q,
    output logic              disp_valid,
    input  logic [1:0]        aux_req,
    input  logic [ADDR_W-1:0] aux_addr0,
    input  logic [ADDR_W-1:0] aux_addr1,
    output logic [1:0]        aux_gnt,
    output logic [DATA_W-1:0] aux_q,
    output logic [1:0]        aux_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [1:0]        starve,
    input  logic              starve_clr
);

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    // Stage 0 travels alongside rom_addr; the remaining ROM_LAT stages cover
    // the ROM's own read latency, so the last stage lines up with rom_q.
    localparam int               PIPE_D  = ROM_LAT + 1;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_AUX1 = 2'd2,
        TAG_AUX2 = 2'd3
    } tag_e;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rr_q, rr_d;          // 0: aux1 preferred, 1: aux2 preferred
    tag_e              tag_q [PIPE_D];
    tag_e              tag_d [PIPE_D];
    tag_e              issue_tag;
    tag_e              tag_out;
    logic [CNT_W-1:0]  wait_cnt_q [2];
    logic [CNT_W-1:0]  wait_cnt_d [2];
    logic [1:0]        starve_q, starve_d;

    // -----------------------------------------------------------------------
    // Arbitration: display first, then the single aux requester, then the
    // aux requester that was not granted most recently.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        aux_gnt = 2'b00;
        if (!reset && !disp_req) begin
            case (aux_req)
                2'b01:   aux_gnt = 2'b01;
                2'b10:   aux_gnt = 2'b10;
                2'b11:   aux_gnt = rr_q ? 2'b10 : 2'b01;
                default: aux_gnt = 2'b00;
            endcase
        end
    end

    // Issue: pick the winner's address and tag; the pointer only moves on an
    // aux grant, and then always to the other requester.
    always_comb begin
        issue_tag  = TAG_NONE;
        rom_addr_d = rom_addr_q;
        rr_d       = rr_q;
        if (disp_req) begin
            issue_tag  = TAG_DISP;
            rom_addr_d = disp_addr;
        end else if (aux_gnt[0]) begin
            issue_tag  = TAG_AUX1;
            rom_addr_d = aux_addr0;
            rr_d       = 1'b1;
        end else if (aux_gnt[1]) begin
            issue_tag  = TAG_AUX2;
            rom_addr_d = aux_addr1;
            rr_d       = 1'b0;
        end
    end

    always_comb begin
        tag_d[0] = issue_tag;
        for (int i = 1; i < PIPE_D; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Starvation: the flag is raised from the registered count, so it
    // appears the cycle after the counter saturates; clear beats set.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            starve_d[i]   = starve_q[i] | (wait_cnt_q[i] == CNT_MAX);
            wait_cnt_d[i] = '0;
            if (starve_clr) begin
                starve_d[i] = 1'b0;
            end else if (aux_req[i] && !aux_gnt[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] == CNT_MAX) ? CNT_MAX
                                                           : wait_cnt_q[i] + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            rom_addr_q <= '0;
            rr_q       <= 1'b0;
            starve_q   <= 2'b00;
            // NOTE: the tag pipeline is reset (unlike a data array) because
            // it is control: stale tags would strobe returns after reset.
            for (int i = 0; i < PIPE_D; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            for (int i = 0; i < 2; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rom_addr_q <= rom_addr_d;
            rr_q       <= rr_d;
            starve_q   <= starve_d;
            for (int i = 0; i < PIPE_D; i++) begin
                tag_q[i] <= tag_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Return routing: data is shared, only the strobes are qualified. The
    // strobes are masked during reset because the tag pipeline still holds
    // pre-reset contents in that cycle.
    // -----------------------------------------------------------------------
    assign tag_out      = tag_q[PIPE_D-1];
    assign disp_q       = rom_q;
    assign aux_q        = rom_q;
    assign disp_valid   = !reset && (tag_out == TAG_DISP);
    assign aux_valid[0] = !reset && (tag_out == TAG_AUX1);
    assign aux_valid[1] = !reset && (tag_out == TAG_AUX2);
    assign rom_addr     = rom_addr_q;
    assign starve       = starve_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Drives two arbiter instances with identical stimulus: one with a 1-cycle
// ROM and one with a 3-cycle ROM, both with STARVE_MAX=8. Each has its own
// behavioural ROM. Expected grants, addresses, starve flags and returns come
// from a reference model that keeps a record of which requester issued a
// read in which cycle and what data that address holds.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 4;
    localparam int STARVE_MAX = 8;
    localparam int LAT_A      = 1;
    localparam int LAT_B      = 3;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic              reset;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [1:0]        aux_req;
    logic [ADDR_W-1:0] aux_addr0;
    logic [ADDR_W-1:0] aux_addr1;
    logic              starve_clr;

    logic [DATA_W-1:0] disp_q_a, aux_q_a, rom_q_a;
    logic              disp_valid_a;
    logic [1:0]        aux_gnt_a, aux_valid_a, starve_a;
    logic [ADDR_W-1:0] rom_addr_a;

    logic [DATA_W-1:0] disp_q_b, aux_q_b, rom_q_b;
    logic              disp_valid_b;
    logic [1:0]        aux_gnt_b, aux_valid_b, starve_b;
    logic [ADDR_W-1:0] rom_addr_b;

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT_A), .STARVE_MAX(STARVE_MAX)
    ) dut_a (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_q(disp_q_a), .disp_valid(disp_valid_a),
        .aux_req(aux_req), .aux_addr0(aux_addr0), .aux_addr1(aux_addr1),
        .aux_gnt(aux_gnt_a), .aux_q(aux_q_a), .aux_valid(aux_valid_a),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a),
        .starve(starve_a), .starve_clr(starve_clr)
    );

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(LAT_B), .STARVE_MAX(STARVE_MAX)
    ) dut_b (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_q(disp_q_b), .disp_valid(disp_valid_b),
        .aux_req(aux_req), .aux_addr0(aux_addr0), .aux_addr1(aux_addr1),
        .aux_gnt(aux_gnt_b), .aux_q(aux_q_b), .aux_valid(aux_valid_b),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b),
        .starve(starve_b), .starve_clr(starve_clr)
    );

    // ROM contents: address mod 16 for the low 256 words, with bits [11:8]
    // folded in so 0x100 and 0x200 hold distinguishable values.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[11:8];
    endfunction

    logic [DATA_W-1:0] rom_pipe_a [LAT_A];
    logic [DATA_W-1:0] rom_pipe_b [LAT_B];

    always @(posedge vga_clk) begin
        rom_pipe_a[0] <= rom_word(rom_addr_a);
        for (int i = 1; i < LAT_A; i++) rom_pipe_a[i] <= rom_pipe_a[i-1];
        rom_pipe_b[0] <= rom_word(rom_addr_b);
        for (int i = 1; i < LAT_B; i++) rom_pipe_b[i] <= rom_pipe_b[i-1];
    end

    assign rom_q_a = rom_pipe_a[LAT_A-1];
    assign rom_q_b = rom_pipe_b[LAT_B-1];

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int                n_tests;
    int                n_fail;
    int                cyc;
    int                last_reset;           // most recent cycle with reset=1
    int                m_last;               // aux requester granted most recently (1 or 2)
    int                m_wait [2];
    logic [1:0]        m_starve;
    logic [ADDR_W-1:0] m_rom_addr;
    logic [1:0]        m_gnt;
    logic [1:0]        iss_who [int];        // issue cycle -> 1 disp, 2 aux1, 3 aux2
    logic [DATA_W-1:0] iss_dat [int];        // issue cycle -> ROM word at that address

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_grant();
        if (reset || disp_req) return 2'b00;
        if (aux_req == 2'b11)  return (m_last == 1) ? 2'b10 : 2'b01;
        return aux_req;
    endfunction

    // A read issued in cycle k returns in cycle k+1+lat unless a reset cycle
    // falls after the issue, up to and including the return cycle.
    task automatic check_ret(input int lat, input string sfx, input logic dv,
                             input logic [1:0] av, input logic [DATA_W-1:0] dq,
                             input logic [DATA_W-1:0] aq);
        int                k;
        logic [1:0]        who;
        logic [DATA_W-1:0] dat;
        k   = cyc - 1 - lat;
        who = 2'd0;
        dat = '0;
        if (k >= 0 && last_reset <= k && iss_who.exists(k)) begin
            who = iss_who[k];
            dat = iss_dat[k];
        end
        check({"disp_valid_", sfx}, 32'(dv), 32'(who == 2'd1));
        check({"aux_valid_", sfx}, 32'(av), 32'({who == 2'd3, who == 2'd2}));
        if (who == 2'd1) check({"disp_q_", sfx}, 32'(dq), 32'(dat));
        if (who >= 2'd2) check({"aux_q_", sfx}, 32'(aq), 32'(dat));
    endtask

    // One clock cycle: inputs are already driven; check at the falling edge,
    // then advance the model across the rising edge.
    task automatic tick();
        @(negedge vga_clk);
        if (reset) last_reset = cyc;
        m_gnt = model_grant();
        check("aux_gnt_a", 32'(aux_gnt_a), 32'(m_gnt));
        check("aux_gnt_b", 32'(aux_gnt_b), 32'(m_gnt));
        check("rom_addr_a", 32'(rom_addr_a), 32'(m_rom_addr));
        check("rom_addr_b", 32'(rom_addr_b), 32'(m_rom_addr));
        check("starve_a", 32'(starve_a), 32'(m_starve));
        check("starve_b", 32'(starve_b), 32'(m_starve));
        check_ret(LAT_A, "a", disp_valid_a, aux_valid_a, disp_q_a, aux_q_a);
        check_ret(LAT_B, "b", disp_valid_b, aux_valid_b, disp_q_b, aux_q_b);

        if (reset) begin
            m_last     = 2;
            m_wait[0]  = 0;
            m_wait[1]  = 0;
            m_starve   = 2'b00;
            m_rom_addr = '0;
        end else begin
            if (disp_req) begin
                iss_who[cyc] = 2'd1;
                iss_dat[cyc] = rom_word(disp_addr);
                m_rom_addr   = disp_addr;
            end else if (m_gnt[0]) begin
                iss_who[cyc] = 2'd2;
                iss_dat[cyc] = rom_word(aux_addr0);
                m_rom_addr   = aux_addr0;
                m_last       = 1;
            end else if (m_gnt[1]) begin
                iss_who[cyc] = 2'd3;
                iss_dat[cyc] = rom_word(aux_addr1);
                m_rom_addr   = aux_addr1;
                m_last       = 2;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_wait[i] == STARVE_MAX) m_starve[i] = 1'b1;
                if (starve_clr) begin
                    m_starve[i] = 1'b0;
                    m_wait[i]   = 0;
                end else if (aux_req[i] && !m_gnt[i]) begin
                    m_wait[i] = (m_wait[i] < STARVE_MAX) ? m_wait[i] + 1 : STARVE_MAX;
                end else begin
                    m_wait[i] = 0;
                end
            end
        end
        cyc++;
        @(posedge vga_clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        aux_req    = 2'b00;
        aux_addr0  = '0;
        aux_addr1  = '0;
        starve_clr = 1'b0;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        last_reset = -1;
        m_last     = 2;
        m_wait[0]  = 0;
        m_wait[1]  = 0;
        m_starve   = 2'b00;
        m_rom_addr = '0;
        m_gnt      = 2'b00;

        // Let one edge apply reset, then check two reset cycles.
        @(posedge vga_clk);
        #1;
        repeat (2) tick();
        reset = 1'b0;

        // Display-only stream, addresses 0..479.
        for (int i = 0; i < 480; i++) begin
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(i);
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // Both aux requesters held high: grants alternate.
        aux_addr0 = 18'h00100;
        aux_addr1 = 18'h00200;
        aux_req   = 2'b11;
        repeat (8) tick();
        aux_req = 2'b00;
        repeat (4) tick();

        // Display preemption: disp_req 1,1,0,1 while aux1 waits.
        aux_addr0 = 18'h00155;
        aux_req   = 2'b01;
        disp_req  = 1'b1;
        disp_addr = 18'h00021;
        tick();
        disp_addr = 18'h00022;
        tick();
        disp_req = 1'b0;
        tick();
        aux_req   = 2'b00;
        disp_req  = 1'b1;
        disp_addr = 18'h00023;
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Starvation: display hogs the ROM while aux2 waits; clear, restart.
        disp_req  = 1'b1;
        disp_addr = 18'h00040;
        aux_addr1 = 18'h002AA;
        aux_req   = 2'b10;
        repeat (12) tick();
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        repeat (12) tick();
        disp_req = 1'b0;
        tick();
        aux_req = 2'b00;
        repeat (2) tick();
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        repeat (4) tick();

        // Reset while an aux1 read is in flight; afterwards aux1 wins first.
        aux_addr0 = 18'h000F3;
        aux_req   = 2'b01;
        tick();
        reset   = 1'b1;
        aux_req = 2'b00;
        tick();
        reset     = 1'b0;
        aux_addr0 = 18'h00107;
        aux_addr1 = 18'h0020B;
        aux_req   = 2'b11;
        tick();
        aux_req = 2'b10;
        tick();
        aux_req = 2'b00;
        repeat (5) tick();

        // Randomized traffic honouring the hold-until-granted handshake.
        for (int n = 0; n < 1500; n++) begin
            disp_req  = ($urandom_range(0, 99) < 40);
            disp_addr = ADDR_W'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (!aux_req[i] || m_gnt[i]) begin
                    aux_req[i] = ($urandom_range(0, 99) < 60);
                    if (i == 0) aux_addr0 = ADDR_W'($urandom);
                    else        aux_addr1 = ADDR_W'($urandom);
                end
            end
            starve_clr = ($urandom_range(0, 99) < 3);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset      = 1'b0;
        disp_req   = 1'b0;
        aux_req    = 2'b00;
        starve_clr = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
